// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter in front of a 4x16 register file.
// Each transaction takes one ACCESS cycle followed by one RESP cycle.
module regfile_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [15:0] rsp_data,
  output logic        busy,
  output logic        rf_write,
  output logic [3:0]  rf_wrAddr,
  output logic [15:0] rf_wrData,
  output logic [3:0]  rf_rdAddr,
  input  logic [15:0] rf_rdData
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} stateT;

  stateT       state, nextState;
  logic        rrPtr;
  logic        winner;
  logic        wrFlag;
  logic [3:0]  addrReg;
  logic [15:0] wdataReg;
  logic [15:0] rspDataReg;
  logic        grant;
  logic        grantIdx;
  logic        inRange;
  logic        inAccess;
  logic        inResp;

  // Next-state and winner selection; rrPtr only matters when both requesters are valid.
  always_comb begin
    nextState = state;
    grant     = 1'b0;
    grantIdx  = (req_valid == 2'b11) ? rrPtr : req_valid[1];
    case (state)
      IDLE: begin
        if (|req_valid) begin
          nextState = ACCESS;
          grant     = 1'b1;
        end
      end
      ACCESS: nextState = RESP;
      RESP: begin
        if (|req_valid) begin
          nextState = ACCESS;
          grant     = 1'b1;
        end else begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rrPtr      <= 1'b0;
      winner     <= 1'b0;
      wrFlag     <= 1'b0;
      addrReg    <= 4'd0;
      wdataReg   <= 16'd0;
      rspDataReg <= 16'd0;
    end else begin
      state <= nextState;
      if (grant) begin
        winner   <= grantIdx;
        rrPtr    <= ~grantIdx;
        wrFlag   <= req_write[grantIdx];
        addrReg  <= req_addr[{grantIdx, 2'b00} +: 4];
        wdataReg <= req_wdata[{grantIdx, 4'b0000} +: 16];
      end
      // Writes and out-of-range reads complete with zero response data.
      if (state == ACCESS) begin
        rspDataReg <= (!wrFlag && inRange) ? rf_rdData : 16'd0;
      end
    end
  end

  assign inRange   = (addrReg[3:2] == 2'b00);
  assign inAccess  = (state == ACCESS) && !rst;
  assign inResp    = (state == RESP) && !rst;

  assign req_ready = inAccess ? (winner ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = inResp ? (winner ? 2'b10 : 2'b01) : 2'b00;
  assign rf_write  = inAccess && wrFlag && inRange;
  assign rsp_data  = rspDataReg;
  assign busy      = (state != IDLE);
  assign rf_wrAddr = addrReg;
  assign rf_rdAddr = addrReg;
  assign rf_wrData = wdataReg;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a 4-entry register file model
// that returns a poison value for out-of-range read addresses.
module tb_regfile_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        busy;
  logic        rf_write;
  logic [3:0]  rf_wrAddr;
  logic [15:0] rf_wrData;
  logic [3:0]  rf_rdAddr;
  logic [15:0] rf_rdData;

  logic [15:0] mem [4];
  int          wrPulses;
  int          total;
  int          bad;

  typedef struct {
    logic        g;
    logic        wr;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [15:0] expData;
    logic        expRfWrite;
  } vecT;

  vecT vecs [10];

  regfile_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .rf_write(rf_write),
    .rf_wrAddr(rf_wrAddr), .rf_wrData(rf_wrData),
    .rf_rdAddr(rf_rdAddr), .rf_rdData(rf_rdData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_rdData = (rf_rdAddr < 4'd4) ? mem[rf_rdAddr[1:0]] : 16'hDEAD;

  always @(posedge clk) begin
    if (rf_write) begin
      mem[rf_wrAddr[1:0]] <= rf_wrData;
      wrPulses <= wrPulses + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst       = 1'b1;
    req_valid = 2'b00;
    req_write = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One single-requester transaction: wait for the grant, check ACCESS, then RESP.
  task automatic applyStimulus(input logic g, input logic wr, input logic [3:0] addr,
                               input logic [15:0] wdata, input logic [15:0] expData,
                               input logic expRfWrite, input string name);
    int   gi;
    int   waitCnt;
    int   wrBefore;
    logic seen;
    gi = int'(g);
    wrBefore = wrPulses;
    req_valid[gi]         = 1'b1;
    req_write[gi]         = wr;
    req_addr[gi*4 +: 4]   = addr;
    req_wdata[gi*16 +: 16] = wdata;
    seen = 1'b0;
    waitCnt = 0;
    while (!seen && waitCnt < 8) begin
      @(negedge clk);
      if (req_ready[gi]) seen = 1'b1;
      else waitCnt++;
    end
    checkOutput({name, " granted"}, 32'(seen), 32'd1);
    if (!seen) begin
      req_valid[gi] = 1'b0;
      return;
    end
    checkOutput({name, " req_ready"}, 32'(req_ready), 32'(2'b01 << gi));
    checkOutput({name, " rf_write"}, 32'(rf_write), 32'(expRfWrite));
    checkOutput({name, " rf_wrAddr"}, 32'(rf_wrAddr), 32'(addr));
    checkOutput({name, " rf_rdAddr"}, 32'(rf_rdAddr), 32'(addr));
    checkOutput({name, " rf_wrData"}, 32'(rf_wrData), 32'(wdata));
    checkOutput({name, " busy"}, 32'(busy), 32'd1);
    req_valid[gi] = 1'b0;
    @(negedge clk);
    checkOutput({name, " rsp_valid"}, 32'(rsp_valid), 32'(2'b01 << gi));
    checkOutput({name, " rsp_data"}, 32'(rsp_data), 32'(expData));
    checkOutput({name, " rf_write in RESP"}, 32'(rf_write), 32'd0);
    checkOutput({name, " write pulses"}, 32'(wrPulses - wrBefore), 32'(expRfWrite));
  endtask

  initial begin
    int   n;
    logic found;
    logic [1:0] expReady;
    logic [1:0] expRsp;

    total = 0;
    bad = 0;
    wrPulses = 0;
    for (int i = 0; i < 4; i++) mem[i] = 16'h0000;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = 8'h00;
    req_wdata = 32'h0;
    rst = 1'b1;

    vecs[0] = '{1'b0, 1'b1, 4'd2, 16'hBEEF, 16'h0000, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 4'd2, 16'h0000, 16'hBEEF, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 4'd7, 16'hFFFF, 16'h0000, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 4'd7, 16'h0000, 16'h0000, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 4'd3, 16'h1234, 16'h0000, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 4'd3, 16'h0000, 16'h1234, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 4'd0, 16'h5A5A, 16'h0000, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 4'd0, 16'h0000, 16'h5A5A, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 4'd1, 16'h0F0F, 16'h0000, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 4'd1, 16'h0000, 16'h0F0F, 1'b0};

    repeat (2) @(negedge clk);
    checkOutput("reset outputs",
                {7'd0, busy, req_ready, rsp_valid, rf_write, rf_wrAddr, rf_rdAddr, 12'd0},
                32'd0);
    checkOutput("reset rsp_data/rf_wrData", {rsp_data, rf_wrData}, 32'd0);
    rst = 1'b0;

    $display("[TB] idle check");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("idle outputs", {10'd0, busy, req_ready, rsp_valid, rf_write, rsp_data}, 32'd0);
    end

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].g, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    vecs[i].expData, vecs[i].expRfWrite, $sformatf("vec%0d", i));
    end

    $display("[TB] contention");
    doReset();
    req_valid = 2'b11;
    req_write = 2'b10;
    req_addr  = {4'd3, 4'd1};
    req_wdata = {16'h1234, 16'h0000};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      expReady = ((c % 2) == 0) ? (((c / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      expRsp   = ((c % 2) == 1) ? ((((c - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      checkOutput($sformatf("contention c%0d req_ready", c), 32'(req_ready), 32'(expReady));
      checkOutput($sformatf("contention c%0d rsp_valid", c), 32'(rsp_valid), 32'(expRsp));
      checkOutput($sformatf("contention c%0d busy", c), 32'(busy), 32'd1);
      if (c == 1) checkOutput("contention read data", 32'(rsp_data), 32'h0F0F);
      if (c == 3) checkOutput("contention write data", 32'(rsp_data), 32'h0000);
    end
    req_valid = 2'b00;
    @(negedge clk);
    checkOutput("contention back to idle", 32'(busy), 32'd0);

    $display("[TB] fairness");
    doReset();
    req_valid = 2'b10;
    req_write = 2'b00;
    req_addr  = {4'd2, 4'd0};
    @(negedge clk);
    checkOutput("fair first grant", 32'(req_ready), 32'(2'b10));
    req_valid[0] = 1'b1;
    n = 0;
    found = 1'b0;
    while (!found && n < 4) begin
      @(negedge clk);
      n++;
      if (req_ready[0]) found = 1'b1;
    end
    checkOutput("fair req0 grant cycle", 32'(found ? n : 99), 32'd2);
    req_valid = 2'b00;
    n = 0;
    while (busy && n < 6) begin
      @(negedge clk);
      n++;
    end
    checkOutput("fair drain idle", 32'(busy), 32'd0);

    $display("[TB] reset during ACCESS");
    req_valid = 2'b01;
    req_write = 2'b01;
    req_addr  = 8'h00;
    req_wdata = {16'h0000, 16'hFFFF};
    @(negedge clk);
    checkOutput("rstmid grant", 32'(req_ready), 32'(2'b01));
    rst = 1'b1;
    #1;
    n = wrPulses;
    checkOutput("rstmid rf_write", 32'(rf_write), 32'd0);
    checkOutput("rstmid req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    checkOutput("rstmid rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rstmid busy", 32'(busy), 32'd0);
    checkOutput("rstmid no write", 32'(wrPulses - n), 32'd0);
    rst = 1'b0;
    req_valid = 2'b00;
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000, 16'h5A5A, 1'b0, "rstmid readback");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
